lsu_mem_unit: RTL and testbench
===============================

Name: lsu_mem_unit

Overview:
Parametrised, sequential load/store unit between the execute stage and a handshaked data-memory port. It replaces the combinational DPI-based LSU.
- Accepts one request at a time.
- Generates byte strobes and lane-aligned write data.
- Issues one bus transaction per request and waits for its response.
- Extracts and sign/zero-extends load data.
- Flags misaligned accesses without touching the bus.
- Holds the result until the writeback stage accepts it.

Parameters:
XLEN, 64, register/data width in bits.
ADDR_W, 64, address width in bits.
BUS_W, 64, memory data-bus width in bits; power of two, BUS_W >= XLEN.

Ports:
clock  in  1  single clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset.
req_valid  in  1  execute-stage request valid.
req_ready  out  1  LSU can accept a request.
req_addr  in  ADDR_W  byte address.
req_wen  in  1  1 = store, 0 = load.
req_size  in  2  log2 of access bytes: 0=B, 1=H, 2=W, 3=D.
req_unsigned  in  1  zero-extend load (ignored for stores).
req_wdata  in  XLEN  store data, LSB-aligned.
resp_valid  out  1  result available.
resp_ready  in  1  writeback accepts result.
resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
resp_misalign  out  1  request was misaligned.
resp_buserr  out  1  bus returned error.
mem_req_valid  out  1  bus request valid.
mem_req_ready  in  1  bus accepts request.
mem_req_addr  out  ADDR_W  req_addr with low log2(BUS_W/8) bits cleared.
mem_req_wen  out  1  store.
mem_req_wdata  out  BUS_W  lane-shifted store data.
mem_req_wstrb  out  BUS_W/8  byte strobes; 0 for loads.
mem_resp_valid  in  1  bus response valid (always accepted).
mem_resp_rdata  in  BUS_W  bus read data.
mem_resp_err  in  1  bus error.

Behaviour:
- FSM states and transitions:
  - IDLE: req_ready=1. On a handshake, latch all request fields. Go to RESP if misaligned, else REQ.
  - REQ: mem_req_valid=1, bus outputs stable. Go to WAIT on mem_req_ready.
  - WAIT: on mem_resp_valid, latch rdata/err and go to RESP.
  - RESP: resp_valid=1, outputs stable. Go to IDLE on resp_ready.
- req_ready is combinational from state only (1 in IDLE). It never depends on resp_ready, so there is no back-to-back issue; minimum period is 4 cycles per request.
- Latency: request accepted at edge N gives mem_req_valid at N+1. With a zero-wait bus responding in the cycle after grant, resp_valid appears at N+3. Misaligned requests give resp_valid at N+1 with no bus activity.
- Misaligned means addr mod (1<<size) != 0.
- Lane math: off = addr[log2(BUS_W/8)-1:0].
  - wstrb = ((1<<(1<<size))-1) << off.
  - wdata = (req_wdata masked to size bytes) << 8*off; other lanes zero.
  - Load: take bytes [off +: 1<<size] of mem_resp_rdata, then sign-extend (req_unsigned=0) or zero-extend to XLEN. A size-3 load with XLEN=64 is passed unchanged.
- Store responses also wait for mem_resp_valid (write ack). resp_rdata=0.
- Errors: mem_resp_err=1 gives resp_buserr=1 and resp_rdata=0. resp_misalign and resp_buserr are never both set.
- mem_resp_valid outside WAIT is ignored.
- Reset (reset=0 at an edge), including mid-transaction: state goes to IDLE. resp_valid=0, mem_req_valid=0, resp_rdata=0, resp_misalign=0, resp_buserr=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wstrb=0, mem_req_wen=0. Any outstanding bus transaction is abandoned; the bus must be reset in the same cycle.
- req_ready=1 in the cycle after reset releases.

Decomposition:
- Shared package (lsu_pkg):
  - state enum {IDLE, REQ, WAIT, RESP}.
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D.
  - function for strobe generation.
- One sub-module, lsu_load_align: combinational lane select plus sign/zero extension, parametrised by XLEN/BUS_W.

Test Plan:
- Load byte signed, addr=0x8000_0003, bus rdata=0x0000_0000_8000_0000 → resp_rdata=0xFFFF_FFFF_FFFF_FF80 (byte 3=0x80); same with req_unsigned=1 → 0x80; mem_req_addr=0x8000_0000, wstrb=0.
- Store half, addr=0x8000_0006, wdata=0x1234_ABCD → mem_req_wstrb=0xC0, mem_req_wdata=0xABCD_0000_0000_0000; response with resp_rdata=0 after ack.
- Misaligned word load at 0x8000_0002 → resp_valid at N+1, resp_misalign=1, mem_req_valid never asserted.
- Backpressure: mem_req_ready low 3 cycles, resp_ready low 2 cycles → bus fields and resp fields held stable; req_ready=0 throughout.
- Bus error on dword load → resp_buserr=1, resp_rdata=0; spurious mem_resp_valid in IDLE → no response.
- Reset asserted while in WAIT → next cycle all outputs at reset values, req_ready=1 after release; a fresh load completes correctly.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access-size
// encodings, byte-strobe and alignment helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Unshifted byte-enable pattern for an access of 1 << size bytes.
  function automatic logic [7:0] lsu_strb(input logic [1:0] size);
    logic [7:0] strb;
    case (size)
      SZ_B:    strb = 8'h01;
      SZ_H:    strb = 8'h03;
      SZ_W:    strb = 8'h0F;
      default: strb = 8'hFF;
    endcase
    return strb;
  endfunction

  // Bit mask covering the low 1 << size bytes of a 64-bit value.
  function automatic logic [63:0] lsu_data_mask(input logic [1:0] size);
    logic [7:0]  strb;
    logic [63:0] mask;
    strb = lsu_strb(size);
    for (int i = 0; i < 8; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

  // An access is misaligned when the address is not a multiple of its size.
  function automatic logic lsu_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = |addr_lo[1:0];
      default: mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data extraction: selects the addressed bytes from the bus word and
// sign- or zero-extends them to XLEN.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int BUS_W = 64,
  parameter int OFF_W = $clog2(BUS_W / 8)
) (
  input  logic [BUS_W-1:0] bus_rdata,
  input  logic [OFF_W-1:0] off,
  input  logic [1:0]       size,
  input  logic             is_unsigned,
  output logic [XLEN-1:0]  rdata
);

  logic [BUS_W-1:0] shifted;
  logic [63:0]      lane;
  logic [63:0]      ext;

  // Shift the addressed byte lane down to bit 0, then extend by access size.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (here via defaults up front), otherwise synthesis infers a latch.
    shifted = bus_rdata >> {off, 3'b000};
    lane    = 64'(shifted);
    ext     = lane;
    case (size)
      SZ_B:    ext = is_unsigned ? 64'(lane[7:0])  : 64'($signed(lane[7:0]));
      SZ_H:    ext = is_unsigned ? 64'(lane[15:0]) : 64'($signed(lane[15:0]));
      SZ_W:    ext = is_unsigned ? 64'(lane[31:0]) : 64'($signed(lane[31:0]));
      default: ext = lane;
    endcase
    rdata = XLEN'(ext);
  end

endmodule

// File: rtl/lsu_mem_unit.sv
// Sequential load/store unit: accepts one execute-stage request at a time,
// issues a single handshaked bus transaction, and holds the result until
// writeback accepts it. Misaligned accesses are answered without bus activity.
module lsu_mem_unit
  import lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64,
  parameter int BUS_W  = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic                 req_wen,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [XLEN-1:0]      req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [XLEN-1:0]      resp_rdata,
  output logic                 resp_misalign,
  output logic                 resp_buserr,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ADDR_W-1:0]    mem_req_addr,
  output logic                 mem_req_wen,
  output logic [BUS_W-1:0]     mem_req_wdata,
  output logic [BUS_W/8-1:0]   mem_req_wstrb,
  input  logic                 mem_resp_valid,
  input  logic [BUS_W-1:0]     mem_resp_rdata,
  input  logic                 mem_resp_err
);

  localparam int STRB_W = BUS_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  lsu_state_e       state;
  logic [OFF_W-1:0] off_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic             wen_q;

  logic [OFF_W-1:0]  req_off;
  logic              req_mis;
  logic [XLEN-1:0]   req_wdata_masked;
  logic [BUS_W-1:0]  wdata_lanes;
  logic [STRB_W-1:0] strb_lanes;
  logic [XLEN-1:0]   load_data;

  assign req_ready        = (state == IDLE);
  assign req_off          = req_addr[OFF_W-1:0];
  assign req_mis          = lsu_misaligned(req_addr[2:0], req_size);
  assign req_wdata_masked = req_wdata & XLEN'(lsu_data_mask(req_size));
  assign wdata_lanes      = BUS_W'(req_wdata_masked) << {req_off, 3'b000};
  assign strb_lanes       = STRB_W'(lsu_strb(req_size)) << req_off;

  lsu_load_align #(
    .XLEN  (XLEN),
    .BUS_W (BUS_W),
    .OFF_W (OFF_W)
  ) u_load_align (
    .bus_rdata   (mem_resp_rdata),
    .off         (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .rdata       (load_data)
  );

  // Request/bus/response FSM with all outputs registered.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      // NOTE: all registers are cleared so outputs read zero after reset and
      // any in-flight transaction is dropped.
      state         <= IDLE;
      off_q         <= '0;
      size_q        <= SZ_B;
      uns_q         <= 1'b0;
      wen_q         <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_misalign <= 1'b0;
      resp_buserr   <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            off_q  <= req_off;
            size_q <= req_size;
            uns_q  <= req_unsigned;
            wen_q  <= req_wen;
            if (req_mis) begin
              state         <= RESP;
              resp_valid    <= 1'b1;
              resp_misalign <= 1'b1;
              resp_buserr   <= 1'b0;
              resp_rdata    <= '0;
            end else begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_req_wen   <= req_wen;
              mem_req_wdata <= req_wen ? wdata_lanes : '0;
              mem_req_wstrb <= req_wen ? strb_lanes : '0;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            state         <= RESP;
            resp_valid    <= 1'b1;
            resp_misalign <= 1'b0;
            resp_buserr   <= mem_resp_err;
            resp_rdata    <= (mem_resp_err || wen_q) ? '0 : load_data;
          end
        end
        default: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_unit.sv
// Self-checking bench for lsu_mem_unit: directed scenarios plus randomized
// transactions compared against a byte-level reference model.
module tb_lsu_mem_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_misalign;
  logic        resp_buserr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic        mem_resp_err;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_mem_unit #(
    .XLEN   (64),
    .ADDR_W (64),
    .BUS_W  (64)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_wen        (req_wen),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_misalign  (resp_misalign),
    .resp_buserr    (resp_buserr),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wstrb  (mem_req_wstrb),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .mem_resp_err   (mem_resp_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference load: gather 2^size bytes starting at byte 'off', then extend.
  function automatic logic [63:0] model_load(input logic [63:0] bus, input int off,
                                             input int size, input logic uns);
    int n;
    logic [63:0] v;
    n = 1 << size;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = bus[8*(off+i) +: 8];
    if (!uns && n < 8 && v[8*n-1]) begin
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_mem_req_valid"}, mem_req_valid, 0);
    check({tag, "_resp_rdata"}, resp_rdata, 0);
    check({tag, "_resp_misalign"}, resp_misalign, 0);
    check({tag, "_resp_buserr"}, resp_buserr, 0);
    check({tag, "_mem_req_addr"}, mem_req_addr, 0);
    check({tag, "_mem_req_wdata"}, mem_req_wdata, 0);
    check({tag, "_mem_req_wstrb"}, mem_req_wstrb, 0);
    check({tag, "_mem_req_wen"}, mem_req_wen, 0);
  endtask

  // One complete request: issue, bus grant after req_stall cycles, bus
  // response after resp_stall cycles, writeback accept after wb_stall cycles.
  task automatic do_txn(input logic [63:0] addr, input logic wen, input logic [1:0] size,
                        input logic uns, input logic [63:0] wdata, input logic [63:0] bus_rdata,
                        input logic err, input int req_stall, input int resp_stall,
                        input int wb_stall);
    int          n;
    int          off;
    logic        mis;
    logic [63:0] e_addr;
    logic [63:0] e_wdata;
    logic [7:0]  e_strb;
    logic [63:0] e_rdata;
    logic        e_buserr;

    n        = 1 << size;
    off      = int'(addr % 64'd8);
    mis      = (addr % 64'(n)) != 0;
    e_addr   = addr - (addr % 64'd8);
    e_strb   = '0;
    e_wdata  = '0;
    if (wen) begin
      for (int i = 0; i < n; i++) begin
        e_strb[off+i]          = 1'b1;
        e_wdata[8*(off+i) +: 8] = wdata[8*i +: 8];
      end
    end
    e_buserr = !mis && err;
    e_rdata  = (mis || err || wen) ? 64'd0 : model_load(bus_rdata, off, int'(size), uns);

    @(negedge clock);
    check("req_ready_idle", req_ready, 1);
    req_valid    = 1'b1;
    req_addr     = addr;
    req_wen      = wen;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    @(negedge clock);
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};

    if (mis) begin
      check("mis_mem_req_valid", mem_req_valid, 0);
      check("mis_resp_valid", resp_valid, 1);
    end else begin
      for (int c = 0; c <= req_stall; c++) begin
        check("bus_valid", mem_req_valid, 1);
        check("bus_addr", mem_req_addr, e_addr);
        check("bus_wen", mem_req_wen, wen);
        check("bus_wstrb", mem_req_wstrb, e_strb);
        if (wen) check("bus_wdata", mem_req_wdata, e_wdata);
        check("busy_req_ready", req_ready, 0);
        check("busy_resp_valid", resp_valid, 0);
        if (c == req_stall) begin
          mem_req_ready = 1'b1;
        end else if ($urandom_range(0, 3) == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = {$urandom, $urandom};
          mem_resp_err   = 1'($urandom);
        end
        @(negedge clock);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
      end
      for (int c = 0; c < resp_stall; c++) begin
        check("wait_mem_req_valid", mem_req_valid, 0);
        check("wait_resp_valid", resp_valid, 0);
        @(negedge clock);
      end
      mem_resp_valid = 1'b1;
      mem_resp_rdata = bus_rdata;
      mem_resp_err   = err;
      @(negedge clock);
      mem_resp_valid = 1'b0;
      mem_resp_err   = 1'b0;
      mem_resp_rdata = {$urandom, $urandom};
      check("resp_valid", resp_valid, 1);
    end

    for (int c = 0; c <= wb_stall; c++) begin
      check("resp_rdata", resp_rdata, e_rdata);
      check("resp_misalign", resp_misalign, mis);
      check("resp_buserr", resp_buserr, e_buserr);
      check("resp_req_ready", req_ready, 0);
      check("resp_mem_req_valid", mem_req_valid, 0);
      if (c == wb_stall) resp_ready = 1'b1;
      @(negedge clock);
      resp_ready = 1'b0;
      if (c < wb_stall) check("resp_hold_valid", resp_valid, 1);
    end
    check("done_resp_valid", resp_valid, 0);
    check("done_req_ready", req_ready, 1);
  endtask

  // A bus response while idle must not produce a writeback response.
  task automatic idle_spurious();
    @(negedge clock);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = {$urandom, $urandom};
    mem_resp_err   = 1'($urandom);
    @(negedge clock);
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
    check("spur_resp_valid", resp_valid, 0);
    check("spur_mem_req_valid", mem_req_valid, 0);
    check("spur_req_ready", req_ready, 1);
  endtask

  initial begin
    reset          = 1'b0;
    req_valid      = 1'b0;
    req_addr       = '0;
    req_wen        = 1'b0;
    req_size       = 2'd0;
    req_unsigned   = 1'b0;
    req_wdata      = '0;
    resp_ready     = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    mem_resp_err   = 1'b0;

    repeat (3) @(negedge clock);
    check_reset_outputs("por");
    reset = 1'b1;
    @(negedge clock);
    check("por_req_ready", req_ready, 1);

    // Signed and unsigned byte loads from byte lane 3.
    do_txn(64'h8000_0003, 1'b0, 2'd0, 1'b0, 64'd0, 64'h0000_0000_8000_0000, 1'b0, 0, 0, 0);
    do_txn(64'h8000_0003, 1'b0, 2'd0, 1'b1, 64'd0, 64'h0000_0000_8000_0000, 1'b0, 0, 0, 0);
    // Halfword store to the top lanes.
    do_txn(64'h8000_0006, 1'b1, 2'd1, 1'b0, 64'h1234_ABCD, 64'hDEAD_BEEF_0000_0000, 1'b0, 0, 0, 0);
    // Misaligned word load.
    do_txn(64'h8000_0002, 1'b0, 2'd2, 1'b0, 64'd0, 64'h1111_2222_3333_4444, 1'b0, 0, 0, 0);
    // Backpressure on both the bus and writeback sides.
    do_txn(64'h8000_0010, 1'b0, 2'd2, 1'b0, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 3, 1, 2);
    // Bus error on a doubleword load, then a spurious response while idle.
    do_txn(64'h8000_0018, 1'b0, 2'd3, 1'b0, 64'd0, 64'hFFFF_0000_FFFF_0000, 1'b1, 0, 0, 0);
    idle_spurious();

    // Reset while waiting for the bus response.
    @(negedge clock);
    req_valid = 1'b1;
    req_addr  = 64'h8000_0020;
    req_wen   = 1'b0;
    req_size  = 2'd3;
    @(negedge clock);
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    check("rst_wait_mem_req_valid", mem_req_valid, 0);
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("midrst");
    reset = 1'b1;
    @(negedge clock);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_resp_valid", resp_valid, 0);
    do_txn(64'h8000_0024, 1'b0, 2'd2, 1'b0, 64'd0, 64'h8765_4321_0000_0000, 1'b0, 0, 0, 0);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 200; t++) begin
      logic [63:0] a;
      a = {$urandom, $urandom};
      do_txn(a, 1'($urandom), 2'($urandom), 1'($urandom), {$urandom, $urandom},
             {$urandom, $urandom}, $urandom_range(0, 7) == 0,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle_spurious();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
